// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipe: mode encodings and the
// width-generic extension function.
package imm_ext_pkg;

    localparam logic [1:0] IMM_MODE_SIGN   = 2'b00;
    localparam logic [1:0] IMM_MODE_ZERO   = 2'b01;
    localparam logic [1:0] IMM_MODE_UPPER  = 2'b10;
    localparam logic [1:0] IMM_MODE_BRANCH = 2'b11;

    // Widest extension the function supports; callers truncate to their own OUT_W.
    localparam int unsigned IMM_MAX_W = 64;

    function automatic logic [IMM_MAX_W-1:0] imm_extend(
        input logic [IMM_MAX_W-1:0] data,
        input logic [1:0]           mode,
        input int unsigned          in_w,
        input int unsigned          out_w,
        input int unsigned          shamt
    );
        logic [IMM_MAX_W-1:0] in_mask;
        logic [IMM_MAX_W-1:0] out_mask;
        logic [IMM_MAX_W-1:0] raw;
        logic [IMM_MAX_W-1:0] top;
        logic [IMM_MAX_W-1:0] sext;
        logic [IMM_MAX_W-1:0] res;

        in_mask  = ~({IMM_MAX_W{1'b1}} << in_w);
        out_mask = ~({IMM_MAX_W{1'b1}} << out_w);
        raw      = data & in_mask;
        top      = raw >> (in_w - 1);
        sext     = top[0] ? (raw | ~in_mask) : raw;

        case (mode)
            IMM_MODE_SIGN:   res = sext;
            IMM_MODE_ZERO:   res = raw;
            IMM_MODE_UPPER:  res = raw << (out_w - in_w);
            IMM_MODE_BRANCH: res = sext << shamt;
            default:         res = '0;
        endcase
        return res & out_mask;
    endfunction

endpackage

// File: rtl/imm_ext_fifo2.sv
// Generic 2-entry valid/ready buffer with synchronous flush. in_ready and
// out_valid are registered copies of the next count so neither depends on out_ready.
module imm_ext_fifo2 #(
    parameter int unsigned DATA_W = 36
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    localparam int unsigned CNT_W = 2;

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              rptr_q, rptr_d;
    logic              wptr_q, wptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              push_c;
    logic              pop_c;

    assign push_c = in_valid_i && ready_q && !flush_i;
    assign pop_c  = valid_q && out_ready_i && !flush_i;

    // Next-state: flush overrides both push and pop.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;

        if (flush_i) begin
            rptr_d  = 1'b0;
            wptr_d  = 1'b0;
            count_d = '0;
        end else begin
            if (push_c) begin
                mem_d[wptr_q] = in_data_i;
                wptr_d        = ~wptr_q;
            end
            if (pop_c) begin
                rptr_d = ~rptr_q;
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        ready_d = (count_d != CNT_W'(2));
        valid_d = (count_d != CNT_W'(0));
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rptr_q   <= 1'b0;
            wptr_q   <= 1'b0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = mem_q[rptr_q];

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: mode mux in front of a 2-entry output buffer.
// Define IMM_EXTEND_PIPE_STATS_EN to add the stat_count/stat_stall counters.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned SHAMT = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
`ifdef IMM_EXTEND_PIPE_STATS_EN
    output logic [31:0]      stat_count_o,
    output logic [31:0]      stat_stall_o,
`endif
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic [1:0]       in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam int unsigned DATA_W = OUT_W + TAG_W;

    if ((IN_W < 2) || (IN_W >= OUT_W) || (IN_W + SHAMT > OUT_W) || (OUT_W > IMM_MAX_W)) begin : g_bad_params
        $fatal(1, "imm_extend_pipe: illegal IN_W/OUT_W/SHAMT combination");
    end

    logic [OUT_W-1:0]  ext_c;
    logic [DATA_W-1:0] head_c;

    // Extension is applied before storage so the buffer holds final results.
    assign ext_c = OUT_W'(imm_extend(IMM_MAX_W'(in_data_i), in_mode_i, IN_W, OUT_W, SHAMT));

    imm_ext_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  ({ext_c, in_tag_i}),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (head_c)
    );

    assign out_data_o = head_c[DATA_W-1:TAG_W];
    assign out_tag_o  = head_c[TAG_W-1:0];

`ifdef IMM_EXTEND_PIPE_STATS_EN
    localparam int unsigned STAT_W = 32;

    logic [STAT_W-1:0] stat_count_q, stat_count_d;
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

    // Pop count wraps; stall count saturates. Neither is affected by flush.
    always_comb begin
        stat_count_d = stat_count_q;
        stat_stall_d = stat_stall_q;
        if (out_valid_o && out_ready_i && !flush_i) begin
            stat_count_d = stat_count_q + STAT_W'(1);
        end
        if (in_valid_i && !in_ready_o && (stat_stall_q != {STAT_W{1'b1}})) begin
            stat_stall_d = stat_stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            stat_count_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_count_q <= stat_count_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_count_o = stat_count_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule
